// File: rtl/matmul_pkg.sv
// Shared widths, signed element types and FSM state encoding for the matmul golden checker.
package matmul_pkg;
    localparam int MATMUL_DATA_WIDTH = 8;
    localparam int MATMUL_BUS_WIDTH  = 16;
    localparam int MATMUL_N_DIM      = 4;

    typedef logic signed [MATMUL_DATA_WIDTH-1:0] matmul_elem_t;
    typedef logic signed [MATMUL_BUS_WIDTH-1:0]  matmul_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_COMPARE,
        ST_DONE
    } matmul_state_t;
endpackage

// File: rtl/matmul_golden_mac.sv
// Single signed multiply-accumulate step; MATMUL_GOLDEN_SAT_EN selects saturating
// accumulation, otherwise the sum wraps in BUS_WIDTH.
module matmul_golden_mac
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = MATMUL_DATA_WIDTH,
    parameter int BUS_WIDTH  = MATMUL_BUS_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [BUS_WIDTH-1:0]  acc,
    output logic signed [BUS_WIDTH-1:0]  acc_next
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

`ifdef MATMUL_GOLDEN_SAT_EN
    // One guard bit above the wider operand is enough to see any overflow.
    localparam int SW = ((BUS_WIDTH > PW) ? BUS_WIDTH : PW) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-BUS_WIDTH+1){1'b0}}, {(BUS_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-BUS_WIDTH+1){1'b1}}, {(BUS_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] sum;

    assign sum = SW'(acc) + SW'(prod);

    always_comb begin
        acc_next = sum[BUS_WIDTH-1:0];
        if (sum > SAT_MAX) begin
            acc_next = SAT_MAX[BUS_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            acc_next = SAT_MIN[BUS_WIDTH-1:0];
        end
    end
`else
    assign acc_next = acc + BUS_WIDTH'(prod);
`endif
endmodule

// File: rtl/matmul_golden_model.sv
// Golden checker: loads A and B, computes C = A*B one MAC per cycle, then compares C
// element-by-element against the DUT result. Saturation option: MATMUL_GOLDEN_SAT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | accept element writes, wait for stim_done_i
// ST_COMPUTE | N_DIM^3 MAC cycles, i,j,k order, k fastest
// ST_COMPARE | N_DIM^2 cycles, one C element vs dut_c_i per cycle
// ST_DONE    | result valid, held until reset
module matmul_golden_model
    import matmul_pkg::*;
#(
    parameter int    DATA_WIDTH   = MATMUL_DATA_WIDTH,
    parameter int    BUS_WIDTH    = MATMUL_BUS_WIDTH,
    parameter int    N_DIM        = MATMUL_N_DIM,
    parameter string matrixC_File = ""
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 wr_en_i,
    input  logic                                 wr_sel_i,
    input  logic [$clog2(N_DIM)-1:0]             wr_row_i,
    input  logic [$clog2(N_DIM)-1:0]             wr_col_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    input  logic                                 stim_done_i,
    input  logic [N_DIM*N_DIM*BUS_WIDTH-1:0]     dut_c_i,
    output logic                                 golden_done_o,
    output logic                                 pass_o,
    output logic [$clog2(N_DIM*N_DIM):0]         mismatch_cnt_o,
    output logic [$clog2(N_DIM*N_DIM)-1:0]       first_err_idx_o
);
    localparam int IW = $clog2(N_DIM);
    localparam int NN = N_DIM * N_DIM;
    localparam int CW = $clog2(NN);
    localparam int MW = CW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIM - 1);
    localparam logic [CW-1:0] LAST_CMP = CW'(NN - 1);

    matmul_state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] a_mem [N_DIM][N_DIM];
    logic signed [DATA_WIDTH-1:0] b_mem [N_DIM][N_DIM];
    logic signed [BUS_WIDTH-1:0]  c_mem [NN];
    logic signed [BUS_WIDTH-1:0]  acc_q, mac_out;
    logic [IW-1:0]                i_q, j_q, k_q;
    logic [CW-1:0]                cmp_idx_q, c_wr_idx;
    logic [MW-1:0]                cnt_q;
    logic [CW-1:0]                first_q;
    logic [BUS_WIDTH-1:0]         dut_elem;
    logic                         row_end, mat_end, cmp_end, mismatch;

    matmul_golden_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_mac (
        .a       (a_mem[i_q][k_q]),
        .b       (b_mem[k_q][j_q]),
        .acc     (acc_q),
        .acc_next(mac_out)
    );

    assign row_end  = (k_q == LAST_IDX);
    assign mat_end  = row_end && (j_q == LAST_IDX) && (i_q == LAST_IDX);
    assign cmp_end  = (cmp_idx_q == LAST_CMP);
    assign c_wr_idx = CW'(int'(i_q) * N_DIM + int'(j_q));
    assign dut_elem = dut_c_i[int'(cmp_idx_q)*BUS_WIDTH +: BUS_WIDTH];
    assign mismatch = (c_mem[cmp_idx_q] != dut_elem);

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (stim_done_i) state_d = ST_COMPUTE;
            ST_COMPUTE: if (mat_end)     state_d = ST_COMPARE;
            ST_COMPARE: if (cmp_end)     state_d = ST_DONE;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int r = 0; r < N_DIM; r++) begin
                for (int c = 0; c < N_DIM; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
            for (int e = 0; e < NN; e++) begin
                c_mem[e] <= '0;
            end
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            cmp_idx_q <= '0;
            cnt_q     <= '0;
            first_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_en_i) begin
                        if (wr_sel_i) begin
                            b_mem[wr_row_i][wr_col_i] <= wr_data_i;
                        end else begin
                            a_mem[wr_row_i][wr_col_i] <= wr_data_i;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (row_end) begin
                        c_mem[c_wr_idx] <= mac_out;
                        acc_q <= '0;
                        k_q   <= '0;
                        j_q   <= (j_q == LAST_IDX) ? '0 : j_q + IW'(1);
                        if (j_q == LAST_IDX) begin
                            i_q <= (i_q == LAST_IDX) ? '0 : i_q + IW'(1);
                        end
                    end else begin
                        acc_q <= mac_out;
                        k_q   <= k_q + IW'(1);
                    end
                end
                ST_COMPARE: begin
                    cmp_idx_q <= cmp_end ? '0 : cmp_idx_q + CW'(1);
                    if (mismatch) begin
                        cnt_q <= cnt_q + MW'(1);
                        if (cnt_q == '0) begin
                            first_q <= cmp_idx_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign golden_done_o   = (state_q == ST_DONE);
    assign pass_o          = (state_q == ST_DONE) && (cnt_q == '0);
    assign mismatch_cnt_o  = cnt_q;
    assign first_err_idx_o = first_q;

`ifndef SYNTHESIS
    // Simulation-only hex dump of C, one row per line, taken as DONE is entered.
    function automatic void dump_c();
        string line;
        for (int r = 0; r < N_DIM; r++) begin
            line = "";
            for (int c = 0; c < N_DIM; c++) begin
                line = {line, $sformatf("%h ", c_mem[r*N_DIM+c])};
            end
            $display("%s", line);
        end
    endfunction

    always @(posedge clk_i) begin
        if (!rst_ni && state_q == ST_COMPARE && state_d == ST_DONE && matrixC_File != "") begin
            dump_c();
        end
    end
`endif
endmodule

// File: tb/tb_matmul_golden_model.sv
// Self-checking bench for matmul_golden_model: N_DIM=2 and N_DIM=4 instances,
// expected outcomes queued at stimulus time and compared when golden_done_o rises.
module tb_matmul_golden_model;
    import matmul_pkg::*;

    localparam int BW = MATMUL_BUS_WIDTH;

    typedef int arr_t [16];
    typedef struct {
        int cnt;
        int first;
        int pass;
        int edges;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst2, wr_en2, wr_sel2, stim2, done2, pass2;
    logic [0:0]     row2, col2;
    logic [7:0]     data2;
    logic [4*BW-1:0] c2;
    logic [2:0]     cnt2;
    logic [1:0]     first2;

    logic           rst4, wr_en4, wr_sel4, stim4, done4, pass4;
    logic [1:0]     row4, col4;
    logic [7:0]     data4;
    logic [16*BW-1:0] c4;
    logic [4:0]     cnt4;
    logic [3:0]     first4;

    matmul_golden_model #(.N_DIM(2)) dut2 (
        .clk_i(clk), .rst_ni(rst2), .wr_en_i(wr_en2), .wr_sel_i(wr_sel2),
        .wr_row_i(row2), .wr_col_i(col2), .wr_data_i(data2), .stim_done_i(stim2),
        .dut_c_i(c2), .golden_done_o(done2), .pass_o(pass2),
        .mismatch_cnt_o(cnt2), .first_err_idx_o(first2)
    );

    matmul_golden_model #(.N_DIM(4)) dut4 (
        .clk_i(clk), .rst_ni(rst4), .wr_en_i(wr_en4), .wr_sel_i(wr_sel4),
        .wr_row_i(row4), .wr_col_i(col4), .wr_data_i(data4), .stim_done_i(stim4),
        .dut_c_i(c4), .golden_done_o(done4), .pass_o(pass4),
        .mismatch_cnt_o(cnt4), .first_err_idx_o(first4)
    );

    int   checks = 0;
    int   failures = 0;
    int   stim_cyc = 0;
    exp_t sb_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic arr_t m4(input int x0, input int x1, input int x2, input int x3);
        arr_t r;
        r = '{default: 0};
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
        return r;
    endfunction

    function automatic arr_t fill(input int n, input int v);
        arr_t r;
        r = '{default: 0};
        for (int i = 0; i < n*n; i++) r[i] = v;
        return r;
    endfunction

    function automatic arr_t model(input int n, input arr_t a, input arr_t b);
        arr_t c;
        int   acc;
        c = '{default: 0};
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int k = 0; k < n; k++) begin
                    acc = acc + a[i*n+k] * b[k*n+j];
`ifdef MATMUL_GOLDEN_SAT_EN
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
`else
                    acc = int'(matmul_bus_t'(acc));
`endif
                end
                c[i*n+j] = acc;
            end
        end
        return c;
    endfunction

    task automatic drive(input int n, input int en, input int sel, input int row,
                         input int col, input int data, input int stim);
        if (n == 2) begin
            wr_en2 = 1'(en); wr_sel2 = 1'(sel); row2 = 1'(row); col2 = 1'(col);
            data2 = 8'(data); stim2 = 1'(stim);
        end else begin
            wr_en4 = 1'(en); wr_sel4 = 1'(sel); row4 = 2'(row); col4 = 2'(col);
            data4 = 8'(data); stim4 = 1'(stim);
        end
    endtask

    task automatic get_outs(input int n, output int done, output int pass,
                            output int cnt, output int first);
        if (n == 2) begin
            done = int'(done2); pass = int'(pass2); cnt = int'(cnt2); first = int'(first2);
        end else begin
            done = int'(done4); pass = int'(pass4); cnt = int'(cnt4); first = int'(first4);
        end
    endtask

    task automatic do_reset(input int n, input string tag);
        int d, p, c, f;
        @(negedge clk);
        drive(n, 0, 0, 0, 0, 0, 0);
        if (n == 2) rst2 = 1'b1; else rst4 = 1'b1;
        @(negedge clk);
        if (n == 2) rst2 = 1'b0; else rst4 = 1'b0;
        get_outs(n, d, p, c, f);
        chk({tag, "_done"}, d, 0);
        chk({tag, "_pass"}, p, 0);
        chk({tag, "_cnt"}, c, 0);
        chk({tag, "_first"}, f, 0);
    endtask

    // Loads A then B; the final B write shares its cycle with stim_done.
    task automatic start(input int n, input arr_t a, input arr_t b, input arr_t cv);
        arr_t mc;
        exp_t e;
        mc = model(n, a, b);
        e.cnt = 0;
        e.first = 0;
        for (int i = 0; i < n*n; i++) begin
            if (n == 2) c2[i*BW +: BW] = BW'(cv[i]);
            else        c4[i*BW +: BW] = BW'(cv[i]);
            if (matmul_bus_t'(mc[i]) != matmul_bus_t'(cv[i])) begin
                if (e.cnt == 0) e.first = i;
                e.cnt++;
            end
        end
        e.pass  = (e.cnt == 0) ? 1 : 0;
        e.edges = n*n*n + n*n + 1;
        sb_q.push_back(e);
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < n*n; i++) begin
                @(negedge clk);
                drive(n, 1, sel, i / n, i % n, (sel == 1) ? b[i] : a[i],
                      (sel == 1 && i == n*n-1) ? 1 : 0);
                if (sel == 1 && i == n*n-1) stim_cyc = cyc;
            end
        end
        @(negedge clk);
        drive(n, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_done(input int n, input string tag);
        int   d, p, c, f, got;
        exp_t e;
        got = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            get_outs(n, d, p, c, f);
            if (d == 1) begin
                got = 1;
                break;
            end
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_done_seen"}, got, 1);
            chk({tag, "_edges"}, cyc - stim_cyc, e.edges);
            chk({tag, "_pass"}, p, e.pass);
            chk({tag, "_cnt"}, c, e.cnt);
            chk({tag, "_first"}, f, e.first);
            repeat (3) @(negedge clk);
            get_outs(n, d, p, c, f);
            chk({tag, "_sticky"}, d, 1);
            chk({tag, "_pass_hold"}, p, e.pass);
        end
    endtask

    initial begin
        int   d, p, c, f;
        int   v127, v128;
        exp_t drop;
        arr_t cv;

`ifdef MATMUL_GOLDEN_SAT_EN
        v127 = 32767;
        v128 = 32767;
`else
        v127 = -1020;
        v128 = -32768;
`endif
        rst2 = 1'b1;
        rst4 = 1'b1;
        c2 = '0;
        c4 = '0;
        drive(2, 0, 0, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0, 0, 0);

        do_reset(2, "rst2");
        do_reset(4, "rst4");

        start(2, m4(1, 0, 0, 1), m4(1, 2, 3, 4), m4(1, 2, 3, 4));
        wait_done(2, "ident");

        do_reset(2, "rst_b");
        start(2, m4(1, 0, 0, 1), m4(1, 2, 3, 4), m4(1, 2, 3, 5));
        wait_done(2, "ident_err");

        do_reset(2, "rst_c");
        start(2, fill(2, -128), fill(2, -128), fill(2, v128));
        wait_done(2, "neg128");

        do_reset(2, "rst_d");
        start(2, m4(3, -7, 12, 5), m4(-2, 9, 4, -11), m4(-34, 100, 0, 53));
        wait_done(2, "mixed_err");

        do_reset(2, "rst_e");
        start(2, fill(2, 5), fill(2, 5), fill(2, 50));
        repeat (4) @(negedge clk);
        get_outs(2, d, p, c, f);
        chk("mid_done_low", d, 0);
        do_reset(2, "mid_rst");
        drop = sb_q.pop_front();
        start(2, m4(2, 1, 0, -1), m4(4, 0, 3, 6), m4(11, 6, -3, -6));
        wait_done(2, "rerun");

        do_reset(2, "rst_f");
        start(2, m4(1, 2, 3, 4), m4(5, 6, 7, 8), m4(19, 22, 43, 50));
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            drive(2, 1, t % 2, 1, t % 2, 100, 0);
        end
        @(negedge clk);
        drive(2, 0, 0, 0, 0, 0, 0);
        wait_done(2, "wr_ignored");

        do_reset(4, "rst4_b");
        start(4, fill(4, 127), fill(4, 127), fill(4, v127));
        wait_done(4, "n4_127");

        do_reset(4, "rst4_c");
        cv = fill(4, 4);
        cv[15] = 3;
        start(4, fill(4, 1), fill(4, 1), cv);
        wait_done(4, "n4_last_err");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
